// File: rtl/flab_pkg.sv
// Shared types, constants and helpers for the flappy-bird game blocks.
package flab_pkg;

   typedef enum logic [1:0] {IDLE, RISE, FALL, OVER} bird_state_t;

   localparam int ROWS    = 8;
   localparam int ROW_W   = 3;
   localparam int TOP_ROW = 7;

   function automatic logic [ROWS-1:0] row_to_onehot(input logic [ROW_W-1:0] r);
      return {{(ROWS-1){1'b0}}, 1'b1} << r;
   endfunction

endpackage

// File: rtl/bird_motion_if.sv
// Control inputs and bird position outputs of the bird motion block.
interface bird_motion_if;
   import flab_pkg::*;

   logic             start;
   logic             ai_enable;
   logic             push;
   logic             flap_btn;
   logic             collide;
   logic [ROWS-1:0]  bird_head;
   logic [ROWS-1:0]  bird_tail;
   logic [ROW_W-1:0] bird_row;
   logic             step;
   logic             game_over;

   modport master (
      output start, ai_enable, push, flap_btn, collide,
      input  bird_head, bird_tail, bird_row, step, game_over
   );

   modport slave (
      input  start, ai_enable, push, flap_btn, collide,
      output bird_head, bird_tail, bird_row, step, game_over
   );

endinterface

// File: rtl/game_tick_gen.sv
// Game step divider: pulses step once every TICK_DIV enabled cycles.
module game_tick_gen #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic step
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign step = (cnt == LAST);

endmodule

// File: rtl/bird_motion.sv
// Bird vertical position: gravity fall, flap rise, ground/collision game over.
//   state | meaning
//   IDLE  | waiting for start, bird parked at START_ROW
//   FALL  | dropping one row per step unless a flap arrives
//   RISE  | climbing one row per step for RISE_STEPS steps
//   OVER  | frozen after ground hit or collision, start returns to IDLE
module bird_motion
   import flab_pkg::*;
#(
   parameter int TICK_DIV   = 25_000_000,
   parameter int RISE_STEPS = 2,
   parameter int START_ROW  = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   bird_motion_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_RISE = 2'(RISE);
   localparam logic [1:0] ST_FALL = 2'(FALL);
   localparam logic [1:0] ST_OVER = 2'(OVER);

   localparam logic [ROW_W-1:0] START  = ROW_W'(START_ROW);
   localparam logic [ROW_W-1:0] TOP    = ROW_W'(TOP_ROW);
   localparam logic [2:0]       RELOAD = 3'(RISE_STEPS - 1);

   logic [1:0]       state;
   logic [ROW_W-1:0] row, prev_row, row_up;
   logic [2:0]       rise_cnt;
   logic             flap_latch;
   logic             running, step, flap_req, tick_clr;

   assign running  = (state == ST_RISE) || (state == ST_FALL);
   assign tick_clr = !running || bus.collide;
   // A button pulse coinciding with the step cycle counts for that step.
   assign flap_req = flap_latch | (bus.ai_enable & bus.push) | (~bus.ai_enable & bus.flap_btn);
   assign row_up   = (row == TOP) ? TOP : row + 1'b1;

   game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (running),
      .clr   (tick_clr),
      .step  (step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flap_latch <= 1'b0;
      end else if (!running || step) begin
         flap_latch <= 1'b0;
      end else if (bus.flap_btn && !bus.ai_enable) begin
         flap_latch <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         row      <= START;
         prev_row <= START;
         rise_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               row      <= START;
               prev_row <= START;
               if (bus.start) state <= ST_FALL;
            end
            ST_OVER: begin
               if (bus.start) begin
                  state    <= ST_IDLE;
                  row      <= START;
                  prev_row <= START;
               end
            end
            default: begin
               if (bus.collide) begin
                  state <= ST_OVER;
               end else if (step) begin
                  if (state == ST_FALL) begin
                     if (flap_req) begin
                        prev_row <= row;
                        row      <= row_up;
                        rise_cnt <= RELOAD;
                        if (RISE_STEPS > 1) state <= ST_RISE;
                     end else if (row != '0) begin
                        prev_row <= row;
                        row      <= row - 1'b1;
                     end else begin
                        state <= ST_OVER;
                     end
                  end else begin
                     prev_row <= row;
                     row      <= row_up;
                     if (flap_req)            rise_cnt <= RELOAD;
                     else if (rise_cnt == 3'd1) state  <= ST_FALL;
                     else                     rise_cnt <= rise_cnt - 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign bus.bird_head = row_to_onehot(row);
   assign bus.bird_tail = row_to_onehot(prev_row);
   assign bus.bird_row  = row;
   assign bus.step      = step;
   assign bus.game_over = (state == ST_OVER);

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion with a per-cycle behavioural reference model.
module tb_bird_motion;

   localparam int TD = 4;
   localparam int RS = 2;
   localparam int SR = 4;

   localparam int M_IDLE = 0, M_RISE = 1, M_FALL = 2, M_OVER = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bird_motion_if bus();

   bird_motion #(.TICK_DIV(TD), .RISE_STEPS(RS), .START_ROW(SR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   int m_mode, m_row, m_prev, m_t, m_rl;
   bit m_latch;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic bit m_running();
      return (m_mode == M_RISE) || (m_mode == M_FALL);
   endfunction

   task automatic m_reset();
      m_mode = M_IDLE; m_row = SR; m_prev = SR; m_t = 0; m_rl = 0; m_latch = 0;
   endtask

   // What the bird must do across the next rising edge, given these inputs.
   task automatic m_advance(input bit st, input bit ai, input bit pu, input bit bt, input bit co);
      bit flap;
      if (!rst_n) begin
         m_reset();
         return;
      end
      flap = m_latch || (ai && pu) || (!ai && bt);
      if (m_mode == M_IDLE) begin
         m_row = SR; m_prev = SR; m_t = 0; m_latch = 0;
         if (st) m_mode = M_FALL;
      end else if (m_mode == M_OVER) begin
         m_t = 0; m_latch = 0;
         if (st) begin m_mode = M_IDLE; m_row = SR; m_prev = SR; end
      end else if (co) begin
         m_mode = M_OVER; m_t = 0; m_latch = 0;
      end else if (m_t == TD - 1) begin
         m_t = 0; m_latch = 0;
         if (m_mode == M_FALL && !flap) begin
            if (m_row > 0) begin m_prev = m_row; m_row = m_row - 1; end
            else m_mode = M_OVER;
         end else begin
            if (m_mode == M_FALL || flap) m_rl = RS - 1;
            else m_rl = m_rl - 1;
            m_prev = m_row;
            m_row  = (m_row < 7) ? m_row + 1 : 7;
            m_mode = (m_rl > 0) ? M_RISE : M_FALL;
         end
      end else begin
         m_t = m_t + 1;
         if (!ai && bt) m_latch = 1;
      end
   endtask

   task automatic compare_all();
      chk("bird_row",  32'(bus.bird_row),  32'(m_row));
      chk("bird_head", 32'(bus.bird_head), 32'(1 << m_row));
      chk("bird_tail", 32'(bus.bird_tail), 32'(1 << m_prev));
      chk("step",      32'(bus.step),      32'(m_running() && m_t == TD - 1));
      chk("game_over", 32'(bus.game_over), 32'(m_mode == M_OVER));
   endtask

   task automatic cyc(input bit st, input bit ai, input bit pu, input bit bt, input bit co);
      bus.start = st; bus.ai_enable = ai; bus.push = pu; bus.flap_btn = bt; bus.collide = co;
      m_advance(st, ai, pu, bt, co);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      bit found;
      bus.start = 0; bus.ai_enable = 0; bus.push = 0; bus.flap_btn = 0; bus.collide = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      chk("rst_head", 32'(bus.bird_head), 32'h10);
      chk("rst_tail", 32'(bus.bird_tail), 32'h10);
      chk("rst_row",  32'(bus.bird_row),  32'd4);
      chk("rst_step", 32'(bus.step),      32'd0);
      chk("rst_over", 32'(bus.game_over), 32'd0);
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // Plain fall to the ground.
      cyc(1, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         repeat (4) cyc(0, 0, 0, 0, 0);
         chk("fall_row", 32'(bus.bird_row), 32'(4 - k));
      end
      repeat (4) cyc(0, 0, 0, 0, 0);
      chk("ground_over", 32'(bus.game_over), 32'd1);
      chk("ground_head", 32'(bus.bird_head), 32'h01);
      repeat (8) cyc(0, 0, 0, 0, 0);
      chk("ground_hold", 32'(bus.bird_head), 32'h01);

      // OVER -> IDLE, step must stay quiet.
      cyc(1, 0, 0, 0, 0);
      chk("idle_head", 32'(bus.bird_head), 32'h10);
      chk("idle_tail", 32'(bus.bird_tail), 32'h10);
      repeat (20) cyc(0, 0, 0, 0, 0);
      chk("idle_step", 32'(bus.step), 32'd0);

      // Button flap before the first step.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      chk("flap_row1", 32'(bus.bird_row),  32'd5);
      chk("flap_tail", 32'(bus.bird_tail), 32'h10);
      chk("flap_head", 32'(bus.bird_head), 32'h20);
      repeat (4) cyc(0, 0, 0, 0, 0);
      chk("flap_row2", 32'(bus.bird_row), 32'd6);
      repeat (4) cyc(0, 0, 0, 0, 0);
      chk("flap_row3", 32'(bus.bird_row), 32'd5);

      // Autopilot push held: climb and saturate at the top row.
      repeat (4) cyc(0, 1, 1, 0, 0);
      chk("ai_row6", 32'(bus.bird_row), 32'd6);
      repeat (4) cyc(0, 1, 1, 0, 0);
      chk("ai_row7", 32'(bus.bird_row), 32'd7);
      repeat (8) cyc(0, 1, 1, 0, 0);
      chk("ai_top_head", 32'(bus.bird_head), 32'h80);
      chk("ai_top_tail", 32'(bus.bird_tail), 32'h80);
      chk("ai_no_over",  32'(bus.game_over), 32'd0);

      // Fall back to row 3, then collide exactly on a step cycle.
      found = 0;
      for (int i = 0; i < 200; i++) begin
         if (m_running() && m_row == 3 && m_t == TD - 1) begin
            found = 1;
            break;
         end
         cyc(0, 1, 0, 0, 0);
      end
      chk("find_row3", 32'(found), 32'd1);
      chk("pre_col_step", 32'(bus.step), 32'd1);
      cyc(0, 1, 0, 0, 1);
      chk("col_over", 32'(bus.game_over), 32'd1);
      chk("col_row",  32'(bus.bird_row),  32'd3);
      repeat (12) cyc(0, 1, 1, 1, 1);
      chk("col_hold", 32'(bus.bird_row), 32'd3);

      // Restart, flap into RISE, then an asynchronous reset mid-rise.
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      chk("rise_row", 32'(bus.bird_row), 32'd5);
      cyc(0, 0, 0, 1, 0);
      bus.flap_btn = 0;
      m_advance(0, 0, 0, 0, 0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      m_reset();
      #1;
      chk("arst_head", 32'(bus.bird_head), 32'h10);
      chk("arst_tail", 32'(bus.bird_tail), 32'h10);
      chk("arst_over", 32'(bus.game_over), 32'd0);
      compare_all();
      @(negedge clk);
      compare_all();
      repeat (2) cyc(0, 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc(1, 0, 0, 0, 0);
      repeat (4) cyc(0, 0, 0, 0, 0);
      chk("restart_row", 32'(bus.bird_row), 32'd3);
      repeat (4) cyc(0, 0, 0, 0, 0);
      chk("restart_row2", 32'(bus.bird_row), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
